// File: rtl/shoot_sequencer_if.sv
// Avalon-MM register port of the kicker sequencer: the CPU side is the master,
// shoot_sequencer is the slave.
interface shoot_sequencer_if;
  logic [1:0]  address;
  logic        write;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (output address, output write, output writedata, input readdata);
  modport slave  (input address, input write, input writedata, output readdata);
endinterface

// File: rtl/shoot_sequencer.sv
// Kicker sequencer: arm, wait for ball, fire flat/chip solenoid, cooldown.
// Optional feature: define SHOOT_SEQ_IRQ_EN to add the irq output and its status bit.
module shoot_sequencer #(
  parameter int CLK_DIV = 50,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  shoot_sequencer_if.slave bus,
  input  logic             shoot_off,
  input  logic             ball_detect,
  output logic             flat_kick,
  output logic             chip_kick,
`ifdef SHOOT_SEQ_IRQ_EN
  output logic             irq,
`endif
  output logic             busy
);

  localparam int PW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRE  = 2'd2,
    COOL  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] pulse_q, pulse_d;
  logic [CNT_W-1:0] cool_q, cool_d;
  logic [7:0]       shot_cnt_q, shot_cnt_d;
  logic             fault_q, fault_d;
  logic             flat_q, flat_d;
  logic             chip_q, chip_d;
  logic [15:0]      readdata_q, readdata_d;
  logic             ball_meta_q, ball_meta_d;
  logic             ball_s_q, ball_s_d;
  logic             inh_meta_q, inh_meta_d;
  logic             inh_s_q, inh_s_d;
  logic             irq_q, irq_d;
  logic             irq_rd;

  logic wr_ctrl, wr_pulse, wr_cool, wr_clr;
  logic arm_req, abort_req;
  logic tick, enter_timed;
  logic fault_set, fire_exit;

  assign wr_ctrl   = bus.write && (bus.address == 2'd0);
  assign wr_pulse  = bus.write && (bus.address == 2'd1);
  assign wr_cool   = bus.write && (bus.address == 2'd2);
  assign wr_clr    = bus.write && (bus.address == 2'd3);
  // Abort beats arm when both bits arrive in the same write.
  assign abort_req = wr_ctrl && bus.writedata[2];
  assign arm_req   = wr_ctrl && bus.writedata[0] && !bus.writedata[2];

  assign tick = (presc_q == PW'(CLK_DIV - 1));

  always_comb begin
    ball_meta_d = ball_detect;
    ball_s_d    = ball_meta_q;
    inh_meta_d  = shoot_off;
    inh_s_d     = inh_meta_q;
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    shot_cnt_d = shot_cnt_q;
    fault_set  = 1'b0;
    fire_exit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm_req && (pulse_q != '0)) begin
          state_d = ARMED;
          mode_d  = bus.writedata[1];
        end
      end
      ARMED: begin
        if (abort_req) begin
          state_d = IDLE;
        end else if (ball_s_q && !inh_s_q) begin
          state_d = FIRE;
          cnt_d   = pulse_q;
        end
      end
      FIRE: begin
        // Inhibit has top priority so a kick never continues under shoot_off.
        if (inh_s_q) begin
          state_d   = COOL;
          cnt_d     = cool_q;
          fault_set = 1'b1;
          fire_exit = 1'b1;
        end else if (abort_req) begin
          state_d   = COOL;
          cnt_d     = cool_q;
          fire_exit = 1'b1;
        end else if (tick) begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d    = COOL;
            cnt_d      = cool_q;
            shot_cnt_d = shot_cnt_q + 8'd1;
            fire_exit  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      COOL: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else if (tick) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The prescaler restarts on entry to a timed state so widths are exact multiples.
  always_comb begin
    enter_timed = (state_d != state_q) && ((state_d == FIRE) || (state_d == COOL));
    if (enter_timed || tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_comb begin
    pulse_d = wr_pulse ? CNT_W'(bus.writedata) : pulse_q;
    cool_d  = wr_cool  ? CNT_W'(bus.writedata) : cool_q;
    fault_d = fault_q;
    if (wr_clr) begin
      fault_d = 1'b0;
    end
    if (fault_set) begin
      fault_d = 1'b1;
    end
    irq_d = irq_q;
    if (wr_clr) begin
      irq_d = 1'b0;
    end
    if (fire_exit) begin
      irq_d = 1'b1;
    end
    flat_d = (state_d == FIRE) && !mode_d;
    chip_d = (state_d == FIRE) && mode_d;
  end

`ifdef SHOOT_SEQ_IRQ_EN
  assign irq_rd = irq_q;
  assign irq    = irq_q;
`else
  assign irq_rd = 1'b0;
`endif

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      2'd0:    readdata_d = {10'd0, irq_rd, fault_q, inh_s_q, ball_s_q, state_q};
      2'd1:    readdata_d = 16'(pulse_q);
      2'd2:    readdata_d = 16'(cool_q);
      default: readdata_d = {8'd0, shot_cnt_q};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      presc_q     <= '0;
      pulse_q     <= '0;
      cool_q      <= '0;
      shot_cnt_q  <= '0;
      fault_q     <= 1'b0;
      flat_q      <= 1'b0;
      chip_q      <= 1'b0;
      readdata_q  <= '0;
      ball_meta_q <= 1'b0;
      ball_s_q    <= 1'b0;
      inh_meta_q  <= 1'b0;
      inh_s_q     <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      presc_q     <= presc_d;
      pulse_q     <= pulse_d;
      cool_q      <= cool_d;
      shot_cnt_q  <= shot_cnt_d;
      fault_q     <= fault_d;
      flat_q      <= flat_d;
      chip_q      <= chip_d;
      readdata_q  <= readdata_d;
      ball_meta_q <= ball_meta_d;
      ball_s_q    <= ball_s_d;
      inh_meta_q  <= inh_meta_d;
      inh_s_q     <= inh_s_d;
      irq_q       <= irq_d;
    end
  end

  assign flat_kick    = flat_q;
  assign chip_kick    = chip_q;
  assign busy         = (state_q != IDLE);
  assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_shoot_sequencer.sv
// Directed bench for shoot_sequencer with CLK_DIV=4; expected values hand-computed.
module tb_shoot_sequencer;
  logic clk = 1'b0;
  logic reset;
  logic shoot_off;
  logic ball_detect;
  logic flat_kick;
  logic chip_kick;
  logic busy;
`ifdef SHOOT_SEQ_IRQ_EN
  logic irq;
  localparam int IRQB = 32;
`else
  localparam int IRQB = 0;
`endif

  int checkCount = 0;
  int passCount  = 0;

  shoot_sequencer_if bus_if ();

  shoot_sequencer #(.CLK_DIV(4), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if),
    .shoot_off   (shoot_off),
    .ball_detect (ball_detect),
    .flat_kick   (flat_kick),
    .chip_kick   (chip_kick),
`ifdef SHOOT_SEQ_IRQ_EN
    .irq         (irq),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] addr, input logic [15:0] data);
    bus_if.address   = addr;
    bus_if.writedata = data;
    bus_if.write     = 1'b1;
    stepCycles(1);
    bus_if.write     = 1'b0;
  endtask

  task automatic readReg(input logic [1:0] addr, output int data);
    bus_if.address = addr;
    stepCycles(1);
    data = int'(bus_if.readdata);
  endtask

  task automatic waitKick(input logic level, input int limit, output int n);
    n = 0;
    while (((flat_kick | chip_kick) != level) && (n < limit)) begin
      stepCycles(1);
      n++;
    end
  endtask

  task automatic waitBusyLow(input int limit, output int n);
    n = 0;
    while (busy && (n < limit)) begin
      stepCycles(1);
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rd;
    int n;
    int w;
    int timeouts;
    logic otherSeen;

    reset            = 1'b1;
    shoot_off        = 1'b0;
    ball_detect      = 1'b0;
    bus_if.address   = 2'd0;
    bus_if.write     = 1'b0;
    bus_if.writedata = 16'd0;
    stepCycles(3);
    checkOutput("rst_flat", 32'(flat_kick), 32'd0);
    checkOutput("rst_chip", 32'(chip_kick), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_readdata", 32'(bus_if.readdata), 32'd0);
    reset = 1'b0;
    readReg(2'd0, rd); checkOutput("rst_ctrl", 32'(rd), 32'd0);
    readReg(2'd1, rd); checkOutput("rst_pulse", 32'(rd), 32'd0);
    readReg(2'd3, rd); checkOutput("rst_shots", 32'(rd), 32'd0);

    $display("[TB] flat shot, PULSE=3 COOL=2");
    applyStimulus(2'd1, 16'd3);
    applyStimulus(2'd2, 16'd2);
    readReg(2'd1, rd); checkOutput("t1_pulse_rd", 32'(rd), 32'd3);
    readReg(2'd2, rd); checkOutput("t1_cool_rd", 32'(rd), 32'd2);
    ball_detect = 1'b1;
    stepCycles(3);
    readReg(2'd0, rd); checkOutput("t1_ball_sync", 32'(rd), 32'd4);
    applyStimulus(2'd0, 16'h0001);
    checkOutput("t1_armed_busy", 32'(busy), 32'd1);
    checkOutput("t1_armed_flat", 32'(flat_kick), 32'd0);
    waitKick(1'b1, 10, n);
    checkOutput("t1_flat_on", 32'(flat_kick), 32'd1);
    w = 0;
    otherSeen = 1'b0;
    while (flat_kick && (w < 100)) begin
      otherSeen = otherSeen | chip_kick;
      w++;
      stepCycles(1);
    end
    checkOutput("t1_flat_width", 32'(w), 32'd12);
    checkOutput("t1_chip_quiet", 32'(otherSeen), 32'd0);
    waitBusyLow(100, n);
    checkOutput("t1_cool_len", 32'(n), 32'd8);
    readReg(2'd3, rd); checkOutput("t1_shots", 32'(rd), 32'd1);
    readReg(2'd0, rd); checkOutput("t1_ctrl_after", 32'(rd), 32'(4 + IRQB));
    applyStimulus(2'd3, 16'd0);

    $display("[TB] chip shot held off by inhibit");
    shoot_off = 1'b1;
    stepCycles(3);
    applyStimulus(2'd0, 16'h0003);
    stepCycles(3);
    readReg(2'd0, rd); checkOutput("t2_armed_inh", 32'(rd), 32'd13);
    checkOutput("t2_no_chip", 32'(chip_kick), 32'd0);
    checkOutput("t2_no_flat", 32'(flat_kick), 32'd0);
    shoot_off = 1'b0;
    waitKick(1'b1, 10, n);
    checkOutput("t2_release_lat", 32'(n), 32'd3);
    checkOutput("t2_chip_on", 32'(chip_kick), 32'd1);
    w = 0;
    otherSeen = 1'b0;
    while (chip_kick && (w < 100)) begin
      otherSeen = otherSeen | flat_kick;
      w++;
      stepCycles(1);
    end
    checkOutput("t2_chip_width", 32'(w), 32'd12);
    checkOutput("t2_flat_quiet", 32'(otherSeen), 32'd0);
    waitBusyLow(100, n);
    readReg(2'd3, rd); checkOutput("t2_shots", 32'(rd), 32'd2);

    $display("[TB] inhibit during fire");
    applyStimulus(2'd0, 16'h0001);
    waitKick(1'b1, 10, n);
    checkOutput("t3_flat_on", 32'(flat_kick), 32'd1);
    stepCycles(4);
    shoot_off = 1'b1;
    waitKick(1'b0, 10, n);
    checkOutput("t3_inh_drop", 32'(n), 32'd3);
    waitBusyLow(100, n);
    checkOutput("t3_idle", 32'(busy), 32'd0);
    readReg(2'd0, rd); checkOutput("t3_fault_set", 32'(rd), 32'(28 + IRQB));
    readReg(2'd3, rd); checkOutput("t3_shots_kept", 32'(rd), 32'd2);
    applyStimulus(2'd3, 16'd0);
    readReg(2'd0, rd); checkOutput("t3_fault_clr", 32'(rd), 32'd12);
    shoot_off = 1'b0;
    stepCycles(3);

    $display("[TB] ignored arm/abort cases");
    applyStimulus(2'd1, 16'd0);
    applyStimulus(2'd0, 16'h0001);
    stepCycles(2);
    checkOutput("t4_pulse0_busy", 32'(busy), 32'd0);
    readReg(2'd0, rd); checkOutput("t4_pulse0_ctrl", 32'(rd), 32'd4);
    applyStimulus(2'd1, 16'd3);
    applyStimulus(2'd0, 16'h0001);
    waitKick(1'b1, 10, n);
    waitKick(1'b0, 20, n);
    checkOutput("t4_in_cool", 32'(busy), 32'd1);
    applyStimulus(2'd0, 16'h0001);
    waitBusyLow(100, n);
    stepCycles(4);
    checkOutput("t4_cool_arm_busy", 32'(busy), 32'd0);
    readReg(2'd3, rd); checkOutput("t4_cool_arm_shots", 32'(rd), 32'd3);
    applyStimulus(2'd0, 16'h0005);
    stepCycles(2);
    checkOutput("t4_arm_abort", 32'(busy), 32'd0);
    ball_detect = 1'b0;
    stepCycles(3);
    applyStimulus(2'd0, 16'h0001);
    checkOutput("t4_armed", 32'(busy), 32'd1);
    applyStimulus(2'd0, 16'h0004);
    checkOutput("t4_abort_armed", 32'(busy), 32'd0);
    ball_detect = 1'b1;
    stepCycles(3);

    $display("[TB] shot counter wrap and reset during fire");
    applyStimulus(2'd1, 16'd1);
    applyStimulus(2'd2, 16'd0);
    timeouts = 0;
    for (int i = 0; i < 253; i++) begin
      applyStimulus(2'd0, 16'h0001);
      waitBusyLow(40, n);
      if (n >= 40) timeouts++;
    end
    checkOutput("t5_timeouts", 32'(timeouts), 32'd0);
    readReg(2'd3, rd); checkOutput("t5_wrap", 32'(rd), 32'd0);
    applyStimulus(2'd1, 16'd3);
    applyStimulus(2'd2, 16'd2);
    applyStimulus(2'd0, 16'h0001);
    waitKick(1'b1, 10, n);
    checkOutput("t5_flat_on", 32'(flat_kick), 32'd1);
    stepCycles(2);
    reset = 1'b1;
    stepCycles(1);
    checkOutput("t5_rst_flat", 32'(flat_kick), 32'd0);
    checkOutput("t5_rst_chip", 32'(chip_kick), 32'd0);
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    checkOutput("t5_rst_readdata", 32'(bus_if.readdata), 32'd0);
    reset = 1'b0;
    readReg(2'd0, rd); checkOutput("t5_rst_ctrl", 32'(rd), 32'd0);
    readReg(2'd1, rd); checkOutput("t5_rst_pulse", 32'(rd), 32'd0);
    readReg(2'd2, rd); checkOutput("t5_rst_cool", 32'(rd), 32'd0);
    readReg(2'd3, rd); checkOutput("t5_rst_shots", 32'(rd), 32'd0);

`ifdef SHOOT_SEQ_IRQ_EN
    $display("[TB] irq behaviour");
    checkOutput("t6_irq_rst", 32'(irq), 32'd0);
    stepCycles(3);
    applyStimulus(2'd1, 16'd1);
    applyStimulus(2'd2, 16'd0);
    applyStimulus(2'd0, 16'h0001);
    waitBusyLow(40, n);
    checkOutput("t6_irq_set", 32'(irq), 32'd1);
    applyStimulus(2'd3, 16'd0);
    checkOutput("t6_irq_clr", 32'(irq), 32'd0);
    applyStimulus(2'd0, 16'h0001);
    waitKick(1'b1, 10, n);
    stepCycles(3);
    applyStimulus(2'd3, 16'd0);
    checkOutput("t6_exit_edge", 32'(flat_kick), 32'd0);
    checkOutput("t6_set_wins", 32'(irq), 32'd1);
    applyStimulus(2'd3, 16'd0);
    checkOutput("t6_irq_clr2", 32'(irq), 32'd0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
